// File: rtl/ps2_port_rx_if.sv
// PS/2 keyboard receiver signal bundle: raw pins in, scancode/strobe/status out.
// slave = receiver side, master = pin driver / scancode consumer side.
`timescale 1ns/1ps

interface ps2_port_rx_if;
   logic       ps2_clk_i;
   logic       ps2_data_i;
   logic [7:0] ps2k_scancode_o;
   logic       ps2k_scodevalid_o;
   logic       ps2k_err_o;
   logic       ps2k_busy_o;

   modport slave (
      input  ps2_clk_i,
      input  ps2_data_i,
      output ps2k_scancode_o,
      output ps2k_scodevalid_o,
      output ps2k_err_o,
      output ps2k_busy_o
   );

   modport master (
      output ps2_clk_i,
      output ps2_data_i,
      input  ps2k_scancode_o,
      input  ps2k_scodevalid_o,
      input  ps2k_err_o,
      input  ps2k_busy_o
   );
endinterface

// File: rtl/ps2_port_rx.sv
// PS/2 device-to-host frame receiver: sync + clock deglitch, 11-bit deserialiser, bit timeout.
// Define PS2_RX_PARITY_CHECK_EN to drop frames with bad odd parity; otherwise only the stop bit is checked.
`timescale 1ns/1ps

module ps2_port_rx #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned BIT_TIMEOUT = 9600
) (
   input  logic           clk,
   input  logic           reset,
   ps2_port_rx_if.slave   bus
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TOW = $clog2(BIT_TIMEOUT);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   logic [1:0]     clk_sync_q;
   logic [1:0]     data_sync_q;
   logic [FCW-1:0] filt_cnt_q,  filt_cnt_d;
   logic           filt_clk_q,  filt_clk_d;
   logic           filt_clk_dly_q;
   state_e         state_q,     state_d;
   logic [2:0]     bit_cnt_q,   bit_cnt_d;
   logic [7:0]     shreg_q,     shreg_d;
   logic [TOW-1:0] to_cnt_q,    to_cnt_d;
   logic [7:0]     scancode_q,  scancode_d;
   logic           valid_q,     valid_d;
   logic           err_q,       err_d;
   logic           fall;
   logic           data_s;
   logic           timeout;
   logic           frame_ok;

`ifdef PS2_RX_PARITY_CHECK_EN
   logic par_q, par_d;
`endif

   assign data_s  = data_sync_q[1];
   assign fall    = filt_clk_dly_q & ~filt_clk_q;
   assign timeout = (to_cnt_q == TOW'(BIT_TIMEOUT - 1));

`ifdef PS2_RX_PARITY_CHECK_EN
   assign frame_ok = data_s & (^{shreg_q, par_q});
`else
   assign frame_ok = data_s;
`endif

   // filt_clk only moves after FILTER_LEN consecutive disagreeing samples
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      filt_cnt_d = '0;
      filt_clk_d = filt_clk_q;
      if (clk_sync_q[1] != filt_clk_q) begin
         if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_clk_d = clk_sync_q[1];
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      scancode_d = scancode_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_d      = par_q;
`endif

      if (state_q == IDLE || fall) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != '1) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end else begin
         to_cnt_d = to_cnt_q;
      end

      case (state_q)
         IDLE: begin
            if (fall && !data_s) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (fall) begin
               shreg_d   = {data_s, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
`ifdef PS2_RX_PARITY_CHECK_EN
               par_d = data_s;
`endif
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               if (frame_ok) begin
                  scancode_d = shreg_q;
                  valid_d    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // a fall in the same cycle as the timeout takes priority
      if (state_q != IDLE && !fall && timeout) begin
         state_d = IDLE;
         err_d   = 1'b1;
         shreg_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q     <= 2'b11;
         data_sync_q    <= 2'b11;
         filt_cnt_q     <= '0;
         filt_clk_q     <= 1'b1;
         filt_clk_dly_q <= 1'b1;
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
         to_cnt_q       <= '0;
         scancode_q     <= '0;
         valid_q        <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         clk_sync_q     <= {clk_sync_q[0], bus.ps2_clk_i};
         data_sync_q    <= {data_sync_q[0], bus.ps2_data_i};
         filt_cnt_q     <= filt_cnt_d;
         filt_clk_q     <= filt_clk_d;
         filt_clk_dly_q <= filt_clk_q;
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         to_cnt_q       <= to_cnt_d;
         scancode_q     <= scancode_d;
         valid_q        <= valid_d;
         err_q          <= err_d;
      end
   end

`ifdef PS2_RX_PARITY_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) par_q <= 1'b0;
      else       par_q <= par_d;
   end
`endif

   assign bus.ps2k_scancode_o   = scancode_q;
   assign bus.ps2k_scodevalid_o = valid_q;
   assign bus.ps2k_err_o        = err_q;
   assign bus.ps2k_busy_o       = (state_q != IDLE);

endmodule

// File: doc/ps2_port_rx.md
# ps2_port_rx

Bit-level PS/2 device-to-host receiver for the keyboard port. It synchronises and deglitches the raw PS/2 clock and data lines, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), and emits each validated byte as a one-cycle scancode strobe. It sits directly upstream of the scancode-to-keycode translator and drives that block's scancode byte and valid inputs.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes level; range 2..255.
- `BIT_TIMEOUT`, 9600: clk cycles allowed between filtered falling edges inside a frame (200 µs at 48 MHz).
- `clk` input 1: system clock, 48 MHz.
- `reset` input 1: asynchronous, active-high reset; one clock.
- `ps2_clk_i` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data_i` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `ps2k_scancode_o` output 8: last received byte; held until the next good frame.
- `ps2k_scodevalid_o` output 1: one-cycle strobe, `ps2k_scancode_o` is new.
- `ps2k_err_o` output 1: one-cycle strobe on a dropped frame (framing, parity or timeout).
- `ps2k_busy_o` output 1: high while a frame is in progress (state not IDLE).

## Operation
- Synchroniser: two flops per pin. Reset value is 1, matching the idle-high bus.
- Clock filter:
  - A counter increments while the synchronised clock differs from `filt_clk`. It clears when they match.
  - When the counter reaches `FILTER_LEN`, `filt_clk` takes the new level and the counter clears.
  - `filt_clk` resets to 1. Data is taken from the synchroniser with no filtering.
- Edge detect: `fall = filt_clk_d & ~filt_clk`. This is the only event that advances the FSM.
- FSM states: IDLE, DATA, PARITY, STOP. All state advances below happen on `fall`.
  - IDLE: data=0 → DATA with `bit_cnt`=0. data=1 → stay in IDLE, no error.
  - DATA: `shreg <= {data, shreg[7:1]}`, `bit_cnt`++. After the 8th bit → PARITY.
  - PARITY: capture data into `par` → STOP.
  - STOP, success: data=1 and `^{shreg, par}`=1 → load `ps2k_scancode_o` from `shreg`, pulse `ps2k_scodevalid_o` → IDLE.
  - STOP, failure: otherwise pulse `ps2k_err_o` → IDLE.
- Timeout:
  - `to_cnt` clears on every `fall` and in IDLE, and increments elsewhere.
  - Reaching `BIT_TIMEOUT - 1` outside IDLE → IDLE, pulse `ps2k_err_o`, discard `shreg`.
  - `to_cnt` is `$clog2(BIT_TIMEOUT)` bits wide and saturates.
- Simultaneous `fall` and timeout in the same cycle: `fall` wins and the timeout counter clears.
- `ps2k_scodevalid_o` and `ps2k_err_o` are never high together. They are never high on consecutive cycles, because frames are ≥ 1 PS/2 bit apart.
- Bytes 0xE0, 0xE1 and 0xF0 are passed through like any other byte. Interpretation belongs downstream.
- Reset values: `ps2k_scancode_o`=0x00, `ps2k_scodevalid_o`=0, `ps2k_err_o`=0, `ps2k_busy_o`=0, FSM=IDLE.
- Reset mid-frame aborts the frame. The trailing bits after reset release either fall through IDLE (data=1) or are discarded by the timeout.

## Timing
- The output strobes are registered. The strobe is high in the cycle after the clk edge on which the FSM sees the final `fall`.
- Latency from a clean raw `ps2_clk_i` falling edge to `fall`: 2 (sync) + `FILTER_LEN` (filter) + 1 (edge register) cycles. The strobe follows 1 cycle later.
- Total latency is `FILTER_LEN` + 4 cycles (±1 for asynchronous sampling), which is 12 cycles at the defaults.
- Data is sampled on the same cycle as `fall`. By then data has been stable for ≥ `FILTER_LEN` + 2 cycles, well inside the device's half-period setup.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk_i` produce no `fall`.
- No back-pressure: the consumer must accept one strobe per ≥ 60 µs.

## Configuration
- `PS2_RX_PARITY_CHECK_EN` defined: behaviour is as above. A parity mismatch drops the frame and pulses `ps2k_err_o`.
- `PS2_RX_PARITY_CHECK_EN` undefined:
  - The parity bit is still clocked through PARITY but is ignored.
  - STOP checks only stop=1. The `par` register is not synthesised.

## Test plan
- Frame 0x1C at a 12 kHz PS/2 clock with correct parity 0 → one `ps2k_scodevalid_o` pulse, `ps2k_scancode_o`=0x1C, `ps2k_err_o` never high.
- Frames 0xE0, 0xF0, 0x75 back-to-back at 16.7 kHz → three strobes carrying exactly those bytes in order, no errors.
- Frame 0x5A with flipped parity → with the macro: no strobe, one `ps2k_err_o` pulse, `ps2k_scancode_o` keeps its old value. Without the macro: strobe with 0x5A.
- Frame 0x29 with stop bit 0 → `ps2k_err_o` pulse and no strobe. A following good frame 0x29 → strobe with 0x29.
- 5-cycle low glitches on `ps2_clk_i` while idle, plus 4 data bits then bus silence → no strobes. Exactly one `ps2k_err_o` pulse 9600 cycles after the last `fall`, and `ps2k_busy_o` drops with it.
- Assert `reset` asynchronously after the 3rd data bit → all outputs 0 immediately. After release, the rest of that frame yields no strobe, and the next full frame 0x16 decodes correctly.
